addsub_serial: RTL and testbench

Parametrised digit-serial adder/subtractor with a valid/ready handshake on both sides. It is the registered, width-generic successor of the 4-bit ripple subtractor, and uses the same complement-and-carry-in scheme. One operation processes DIGIT bits per clock over WIDTH/DIGIT cycles. It reports result, carry/no-borrow, signed overflow and zero flags, and sits between operand-issuing control logic and a result consumer in the datapath.

---
 rtl/addsub_serial.sv | 150 +++++++++++++++
 tb/tb_addsub_serial.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_serial.sv
// ---------------------------------------------------------------------------
// addsub_serial
//   Digit-serial adder/subtractor. An accepted operand set is processed
//   DIGIT bits per clock, LSB digit first, over N = WIDTH/DIGIT cycles.
//   Subtraction reuses the adder: b is inverted at capture and the initial
//   carry is 1 (a + ~b + 1 = a - b).
//
// Parameters
//   WIDTH     operand/result width in bits (>= 2)
//   DIGIT     bits processed per cycle; must divide WIDTH
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand set present on a, b, sub
//   in_ready   block can accept an operand set (registered)
//   a, b       operands
//   sub        1 = a - b, 0 = a + b
//   out_valid  s and flags valid; held until out_ready
//   out_ready  consumer accepts the result
//   s          result modulo 2^WIDTH
//   cout       carry out of the MSB (subtract: 1 = no borrow)
//   ovf        two's-complement signed overflow
//   zero       s == 0
// ---------------------------------------------------------------------------
module addsub_serial #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e             state_q;
   logic [WIDTH-1:0]   op_a_q;
   logic [WIDTH-1:0]   op_b_q;
   logic [WIDTH-1:0]   res_q;
   logic               carry_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               in_ready_q;
   logic               out_valid_q;
   logic [WIDTH-1:0]   s_q;
   logic               cout_q;
   logic               ovf_q;
   logic               zero_q;

   // Digit datapath
   logic [DIGIT:0]     dsum;
   logic               msb_cin;
   logic [WIDTH-1:0]   res_d;
   logic               last_digit;

   always_comb begin
      dsum       = {1'b0, op_a_q[DIGIT-1:0]} + {1'b0, op_b_q[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, carry_q};
      // Carry into the top bit of this digit, recovered from the sum bit.
      // On the final digit this is the carry into bit WIDTH-1.
      msb_cin    = op_a_q[DIGIT-1] ^ op_b_q[DIGIT-1] ^ dsum[DIGIT-1];
      // New digit enters at the top; after N shifts the LSB digit sits at
      // bit 0. Written as a shift of the concatenation so DIGIT = WIDTH works.
      res_d      = WIDTH'({dsum[DIGIT-1:0], res_q} >> DIGIT);
      last_digit = (cnt_q == CNT_W'(N - 1));
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_a_q      <= '0;
         op_b_q      <= '0;
         res_q       <= '0;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         s_q         <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               // Rises one edge after reset release; the accept condition
               // uses the registered value, so nothing is taken on that edge.
               in_ready_q <= 1'b1;
               if (in_valid && in_ready_q) begin
                  op_a_q     <= a;
                  op_b_q     <= sub ? ~b : b;
                  carry_q    <= sub;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= RUN;
               end
            end

            RUN: begin
               op_a_q  <= op_a_q >> DIGIT;
               op_b_q  <= op_b_q >> DIGIT;
               carry_q <= dsum[DIGIT];
               res_q   <= res_d;
               cnt_q   <= cnt_q + 1'b1;
               if (last_digit) begin
                  // Outputs load only here, so no partial result is visible.
                  s_q         <= res_d;
                  cout_q      <= dsum[DIGIT];
                  ovf_q       <= msb_cin ^ dsum[DIGIT];
                  zero_q      <= ~|res_d;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end

            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign s         = s_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_addsub_serial.sv
// ---------------------------------------------------------------------------
// tb_addsub_serial
//   Directed bench for addsub_serial. Two instances share the stimulus:
//   WIDTH=16/DIGIT=4 and WIDTH=8/DIGIT=8; sel8 picks which one is driven
//   and observed.
// ---------------------------------------------------------------------------
module tb_addsub_serial;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic [15:0] a_tb;
   logic [15:0] b_tb;
   logic        sub_tb;
   logic        sel8;

   logic        in_ready16, out_valid16, cout16, ovf16, zero16;
   logic [15:0] s16;
   logic        in_ready8, out_valid8, cout8, ovf8, zero8;
   logic [7:0]  s8;

   logic        obs_in_ready, obs_out_valid, obs_cout, obs_ovf, obs_zero;
   logic [15:0] obs_s;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   addsub_serial #(.WIDTH(16), .DIGIT(4)) dut16 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid & ~sel8),
      .in_ready  (in_ready16),
      .a         (a_tb),
      .b         (b_tb),
      .sub       (sub_tb),
      .out_valid (out_valid16),
      .out_ready (out_ready & ~sel8),
      .s         (s16),
      .cout      (cout16),
      .ovf       (ovf16),
      .zero      (zero16)
   );

   addsub_serial #(.WIDTH(8), .DIGIT(8)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid & sel8),
      .in_ready  (in_ready8),
      .a         (a_tb[7:0]),
      .b         (b_tb[7:0]),
      .sub       (sub_tb),
      .out_valid (out_valid8),
      .out_ready (out_ready & sel8),
      .s         (s8),
      .cout      (cout8),
      .ovf       (ovf8),
      .zero      (zero8)
   );

   assign obs_in_ready  = sel8 ? in_ready8  : in_ready16;
   assign obs_out_valid = sel8 ? out_valid8 : out_valid16;
   assign obs_s         = sel8 ? {8'h00, s8} : s16;
   assign obs_cout      = sel8 ? cout8 : cout16;
   assign obs_ovf       = sel8 ? ovf8  : ovf16;
   assign obs_zero      = sel8 ? zero8 : zero16;

   task automatic chk(input string tag, input logic [31:0] observed,
                      input logic [31:0] expected);
      n_vec++;
      assert (observed === expected) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic check_result(input string tag, input logic [15:0] es,
                               input logic ec, input logic ev, input logic ez);
      chk({tag, "_s"},    obs_s,    es);
      chk({tag, "_cout"}, obs_cout, ec);
      chk({tag, "_ovf"},  obs_ovf,  ev);
      chk({tag, "_zero"}, obs_zero, ez);
   endtask

   // Present an operand set at a falling edge; returns on the accept edge.
   task automatic issue(input string tag, input logic [15:0] ia,
                        input logic [15:0] ib, input logic isub);
      @(negedge clk);
      chk({tag, "_in_ready"}, obs_in_ready, 1'b1);
      a_tb     = ia;
      b_tb     = ib;
      sub_tb   = isub;
      in_valid = 1'b1;
      @(posedge clk);
   endtask

   // Count rising edges after acceptance until out_valid is seen.
   task automatic wait_done(input string tag, input int exp_lat);
      int cyc = 0;
      @(negedge clk);
      in_valid = 1'b0;
      a_tb     = 16'hDEAD;
      b_tb     = 16'hBEEF;
      sub_tb   = ~sub_tb;
      while (!obs_out_valid && cyc < 40) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      chk({tag, "_latency"}, cyc, exp_lat);
   endtask

   task automatic release_result(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_out_valid_drop"}, obs_out_valid, 1'b0);
      chk({tag, "_in_ready_back"},  obs_in_ready,  1'b1);
   endtask

   // Reference: signed overflow from operand/result sign bits.
   task automatic model(input int w, input logic [15:0] ia, input logic [15:0] ib,
                        input logic isub, output logic [15:0] es,
                        output logic ec, output logic ev, output logic ez);
      logic [16:0] full;
      logic [15:0] m;
      logic [15:0] am;
      logic [15:0] bb;
      m    = 16'((17'd1 << w) - 17'd1);
      am   = ia & m;
      bb   = (isub ? ~ib : ib) & m;
      full = {1'b0, am} + {1'b0, bb} + {16'd0, isub};
      es   = full[15:0] & m;
      ec   = full[w];
      ev   = (am[w-1] == bb[w-1]) && (es[w-1] != am[w-1]);
      ez   = (es == 16'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] ra, rb, es;
      logic        rs, ec, ev, ez;

      sel8      = 1'b0;
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      a_tb      = 16'h0001;
      b_tb      = 16'h0003;
      sub_tb    = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_in_ready",  obs_in_ready,  1'b0);
      chk("rst_out_valid", obs_out_valid, 1'b0);
      check_result("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;

      // First edge after release: in_ready rises, operand not taken
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_not_accepted", obs_in_ready, 1'b1);
      in_valid = 1'b0;

      // 0x0001 - 0x0003
      issue("sub1", 16'h0001, 16'h0003, 1'b1);
      wait_done("sub1", 4);
      check_result("sub1", 16'hFFFE, 1'b0, 1'b0, 1'b0);
      release_result("sub1");

      // 0x8000 - 0x0001, out_ready already high before out_valid
      out_ready = 1'b1;
      issue("sub2", 16'h8000, 16'h0001, 1'b1);
      wait_done("sub2", 4);
      check_result("sub2", 16'h7FFF, 1'b1, 1'b1, 1'b0);
      release_result("sub2");

      // 0x7FFF + 0x0001
      issue("add1", 16'h7FFF, 16'h0001, 1'b0);
      wait_done("add1", 4);
      check_result("add1", 16'h8000, 1'b0, 1'b1, 1'b0);
      release_result("add1");

      // Reset during the second RUN cycle
      issue("abort", 16'h5555, 16'h1111, 1'b0);
      in_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_out_valid", obs_out_valid, 1'b0);
      chk("abort_in_ready",  obs_in_ready,  1'b0);
      check_result("abort", 16'h0000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("abort_hold_in_ready", obs_in_ready, 1'b0);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_release_in_ready", obs_in_ready,  1'b1);
      chk("abort_no_result",        obs_out_valid, 1'b0);

      issue("after_abort", 16'h1234, 16'h0234, 1'b1);
      wait_done("after_abort", 4);
      check_result("after_abort", 16'h1000, 1'b1, 1'b0, 1'b0);
      release_result("after_abort");

      // 0xFFFF + 0x0001
      issue("add2", 16'hFFFF, 16'h0001, 1'b0);
      wait_done("add2", 4);
      check_result("add2", 16'h0000, 1'b1, 1'b0, 1'b1);
      release_result("add2");

      // 0x0003 - 0x0003, then backpressure with new operands offered
      issue("sub3", 16'h0003, 16'h0003, 1'b1);
      wait_done("sub3", 4);
      check_result("sub3", 16'h0000, 1'b1, 1'b0, 1'b1);
      a_tb     = 16'hAAAA;
      b_tb     = 16'h1111;
      sub_tb   = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("bp_out_valid", obs_out_valid, 1'b1);
         chk("bp_in_ready",  obs_in_ready,  1'b0);
         check_result("bp", 16'h0000, 1'b1, 1'b0, 1'b1);
      end
      in_valid = 1'b0;
      release_result("bp");
      @(posedge clk);
      @(negedge clk);
      chk("bp_nothing_accepted", obs_out_valid, 1'b0);

      // WIDTH=8, DIGIT=8 instance
      sel8 = 1'b1;
      issue("w8_sub", 16'h0005, 16'h000B, 1'b1);
      wait_done("w8_sub", 1);
      check_result("w8_sub", 16'h00FA, 1'b0, 1'b0, 1'b0);
      release_result("w8_sub");

      // Random back-to-back operations on both instances
      out_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         sel8 = (k == 1);
         for (int i = 0; i < 16; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            model(sel8 ? 8 : 16, ra, rb, rs, es, ec, ev, ez);
            issue("rnd", ra, rb, rs);
            wait_done("rnd", sel8 ? 1 : 4);
            check_result("rnd", es, ec, ev, ez);
            release_result("rnd");
         end
      end
      out_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
